// File: rtl/nonce_search_ctrl.sv
// Nonce search sequencer: walks header RAM entries, sweeps nonces through the hash core, reports first hit or miss.
// Optional `NONCE_STATS_EN adds o_attempts, a saturating count of hash launches since the last accepted start.
module nonce_search_ctrl #(
  parameter int unsigned            NUM_ENTRIES = 4,
  parameter int unsigned            HDR_SIZE    = 96,
  parameter int unsigned            NONCE_SIZE  = 32,
  parameter int unsigned            HASH_SIZE   = 24,
  parameter logic [NONCE_SIZE-1:0]  NONCE_MAX   = {NONCE_SIZE{1'b1}}
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic [HASH_SIZE-1:0]           i_target,
  output logic [1:0]                     o_rd_ptr,
  input  logic [HDR_SIZE-1:0]            i_entrada,
  output logic [HDR_SIZE+NONCE_SIZE-1:0] o_bloque_out,
  output logic                           o_hash_start,
  input  logic                           i_hash_done,
  input  logic [HASH_SIZE-1:0]           i_hash_in,
  output logic                           o_result_valid,
  output logic                           o_result_hit,
  output logic [1:0]                     o_result_entry,
  output logic [NONCE_SIZE-1:0]          o_result_nonce,
  output logic                           o_busy,
  output logic                           o_run_done
`ifdef NONCE_STATS_EN
  ,
  output logic [31:0]                    o_attempts
`endif
);

  localparam int unsigned ENTRY_W = 2;
  localparam int unsigned BLOCK_W = HDR_SIZE + NONCE_SIZE;
  localparam int unsigned ATT_W   = 32;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_LAUNCH = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;
  localparam logic [2:0] S_REPORT = 3'd6;

  logic [2:0]            r_state;
  logic [2:0]            w_next_state;
  logic [HASH_SIZE-1:0]  r_target;
  logic [ENTRY_W-1:0]    r_entry;
  logic [HDR_SIZE-1:0]   r_header;
  logic [NONCE_SIZE-1:0] r_nonce;
  logic [HASH_SIZE-1:0]  r_digest;

  logic [ENTRY_W-1:0]    r_rd_ptr;
  logic [BLOCK_W-1:0]    r_bloque;
  logic                  r_hash_start;
  logic                  r_result_valid;
  logic                  r_result_hit;
  logic [ENTRY_W-1:0]    r_result_entry;
  logic [NONCE_SIZE-1:0] r_result_nonce;
  logic                  r_busy;
  logic                  r_run_done;

  logic                  w_hit;
  logic                  w_last_nonce;
  logic                  w_last_entry;
  logic                  w_accept;
  logic [HDR_SIZE-1:0]   w_next_header;
  logic [NONCE_SIZE-1:0] w_next_nonce;

  assign w_hit        = (r_digest < r_target);
  assign w_last_nonce = (r_nonce == NONCE_MAX);
  assign w_last_entry = (r_entry == ENTRY_W'(NUM_ENTRIES - 1));
  assign w_accept     = (r_state == S_IDLE) && i_start;

  // Next state plus the header/nonce that the next launch will use
  always_comb begin
    w_next_state  = r_state;
    w_next_header = r_header;
    w_next_nonce  = r_nonce;
    case (r_state)
      S_IDLE:   if (i_start) w_next_state = S_FETCH;
      S_FETCH:  w_next_state = S_LOAD;
      S_LOAD: begin
        w_next_state  = S_LAUNCH;
        w_next_header = i_entrada;
        w_next_nonce  = '0;
      end
      S_LAUNCH: w_next_state = S_WAIT;
      S_WAIT:   if (i_hash_done) w_next_state = S_CHECK;
      S_CHECK: begin
        if (w_hit || w_last_nonce) begin
          w_next_state = S_REPORT;
        end else begin
          w_next_state = S_LAUNCH;
          w_next_nonce = r_nonce + NONCE_SIZE'(1);
        end
      end
      S_REPORT: w_next_state = w_last_entry ? S_IDLE : S_FETCH;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Datapath and registered outputs; pulses are set on entry to their state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_target       <= '0;
      r_entry        <= '0;
      r_header       <= '0;
      r_nonce        <= '0;
      r_digest       <= '0;
      r_rd_ptr       <= '0;
      r_bloque       <= '0;
      r_hash_start   <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_hit   <= 1'b0;
      r_result_entry <= '0;
      r_result_nonce <= '0;
      r_busy         <= 1'b0;
      r_run_done     <= 1'b0;
    end else begin
      r_header       <= w_next_header;
      r_nonce        <= w_next_nonce;
      r_busy         <= (w_next_state != S_IDLE);
      r_hash_start   <= (w_next_state == S_LAUNCH);
      r_result_valid <= (r_state == S_CHECK) && (w_next_state == S_REPORT);
      r_run_done     <= (r_state == S_CHECK) && (w_next_state == S_REPORT) && w_last_entry;

      if (w_accept) begin
        r_target <= i_target;
        r_entry  <= '0;
        r_rd_ptr <= '0;
      end

      if (w_next_state == S_LAUNCH) r_bloque <= {w_next_header, w_next_nonce};

      if ((r_state == S_WAIT) && i_hash_done) r_digest <= i_hash_in;

      if ((r_state == S_CHECK) && (w_next_state == S_REPORT)) begin
        r_result_hit   <= w_hit;
        r_result_entry <= r_entry;
        r_result_nonce <= r_nonce;
      end

      if ((r_state == S_REPORT) && !w_last_entry) begin
        r_entry  <= r_entry + ENTRY_W'(1);
        r_rd_ptr <= r_entry + ENTRY_W'(1);
      end
    end
  end

`ifdef NONCE_STATS_EN
  logic [ATT_W-1:0] r_attempts;

  // Saturating launch counter, cleared by reset or an accepted start
  always_ff @(posedge i_clk) begin
    if (i_reset || w_accept) begin
      r_attempts <= '0;
    end else if ((w_next_state == S_LAUNCH) && (r_attempts != {ATT_W{1'b1}})) begin
      r_attempts <= r_attempts + ATT_W'(1);
    end
  end

  assign o_attempts = r_attempts;
`endif

  assign o_rd_ptr       = r_rd_ptr;
  assign o_bloque_out   = r_bloque;
  assign o_hash_start   = r_hash_start;
  assign o_result_valid = r_result_valid;
  assign o_result_hit   = r_result_hit;
  assign o_result_entry = r_result_entry;
  assign o_result_nonce = r_result_nonce;
  assign o_busy         = r_busy;
  assign o_run_done     = r_run_done;

endmodule

// File: doc/nonce_search_ctrl.md
Name: nonce_search_ctrl

Overview:
- Sequencer between the 4-entry header RAM (96-bit words, selected by a 2-bit read pointer, 1-cycle registered read) and the hash core.
- Walks header entries 0..NUM_ENTRIES-1. For each entry it sweeps a 32-bit nonce, launches one hash per {header, nonce} block, and compares each digest against a target.
- Reports the first winning nonce per entry, or a miss when the nonce limit is hit.

Parameters:
- NUM_ENTRIES, 4, header entries walked per run (1..4)
- HDR_SIZE, 96, header word width from RAM
- NONCE_SIZE, 32, nonce width appended to the header
- HASH_SIZE, 24, digest width returned by the hash core
- NONCE_MAX, 32'hFFFF_FFFF, last nonce tried per entry

Ports:
- clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- start  in  1  level-sampled, begins a run from IDLE
- target  in  HASH_SIZE  digest must be strictly less than this; sampled at start
- rd_ptr  out  2  RAM read address
- entrada  in  HDR_SIZE  RAM read data, valid 1 cycle after rd_ptr
- bloque_out  out  HDR_SIZE+NONCE_SIZE  {header, nonce} block to hash core
- hash_start  out  1  1-cycle launch pulse
- hash_done  in  1  1-cycle pulse, digest valid
- hash_in  in  HASH_SIZE  digest from core
- result_valid  out  1  1-cycle pulse per finished entry
- result_hit  out  1  1 = nonce found, 0 = NONCE_MAX exhausted
- result_entry  out  2  entry index of the result
- result_nonce  out  NONCE_SIZE  winning nonce (last nonce tried on miss)
- busy  out  1  high whenever state != IDLE
- run_done  out  1  1-cycle pulse after the last entry's result

Behaviour:
- Reset (regardless of state, including mid-hash): state=IDLE; all outputs 0; rd_ptr=0; bloque_out=0; entry counter and nonce=0. A hash_done arriving in the cycle reset is high is ignored.
- IDLE: if start=1, latch target, set entry=0, rd_ptr=0, go to FETCH. start is ignored in all other states.
- FETCH (1 cycle): RAM read in flight; go to LOAD.
- LOAD: latch entrada into the header register, set nonce=0, go to LAUNCH.
- LAUNCH: drive bloque_out={header, nonce}, pulse hash_start for exactly one cycle, go to WAIT.
- WAIT: hold bloque_out stable until hash_done. There is no timeout.
- On hash_done, go to CHECK, with hash_in captured that cycle. Then:
  - captured digest < target (unsigned): hit.
  - else if nonce == NONCE_MAX: miss.
  - else nonce <= nonce+1, back to LAUNCH.
- Nonce never wraps: NONCE_MAX is terminal.
- Attempt rate: hash_start-to-hash_start minimum is 3 cycles plus core latency (LAUNCH, WAIT≥1, CHECK).
- REPORT (1 cycle): result_valid=1 with result_hit, result_entry=entry, result_nonce=nonce.
  - If entry == NUM_ENTRIES-1: pulse run_done in the same cycle and go to IDLE.
  - Else entry+1, rd_ptr=entry+1, go to FETCH.
- result_* hold their last values between pulses; only result_valid and run_done pulse.
- A hash_done outside WAIT is ignored.
- target == 0 never hits; every entry ends as a miss at NONCE_MAX.

Optional Feature:
- Macro NONCE_STATS_EN.
- Defined: add output attempts (32 bits). It counts hash_start pulses since the last start accepted from IDLE, saturates at 32'hFFFF_FFFF, clears on reset and on a new start.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. RAM loaded with the four codebase headers, target=24'hFFFFFF, core returns 24'h000001 → entries 0..3 each hit with nonce 0. rd_ptr sequence is 0,1,2,3. bloque_out[127:32]=24'h... equals 96'h397d9f2f40ca9e6c6b1f3324 for entry 0. run_done follows entry 3's result_valid in the same cycle.
2. target=24'h000100, core returns 24'h000200 for nonces 0..4 and 24'h0000FF for nonce 5 → result_hit=1, result_nonce=5, six hash_start pulses for that entry.
3. NONCE_MAX=7 override, target=0 → each entry misses with result_nonce=7 after exactly 8 attempts; result_hit=0.
4. Assert reset in WAIT while the core is mid-hash, and deliver hash_done in the same cycle → all outputs 0, state IDLE, busy=0, no result_valid. Then a fresh start restarts at entry 0, nonce 0.
5. Pulse start while busy, and pulse hash_done in CHECK/REPORT → no change in sequencing, attempt count or results.
6. With NONCE_STATS_EN, rerun scenario 2 on all entries → attempts=6+3=9 at run_done (one entry hitting at 5, three at 0). A new start clears it to 0.
